// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and defaults for the program-run sequencer.
//   state_e        : sequencer states (3-bit encoding)
//   CYC_W_DEF      : default cycle-counter width
//   PC_W_DEF       : default program-counter width
//   PROGn_BASE_DEF : default PC start address of each InstROM program
//   next_prog()    : program index advance with wrap at num_progs-1
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_LOAD = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int CYC_W_DEF = 16;
    localparam int PC_W_DEF  = 10;

    localparam logic [PC_W_DEF-1:0] PROG0_BASE_DEF = 10'd0;
    localparam logic [PC_W_DEF-1:0] PROG1_BASE_DEF = 10'd256;
    localparam logic [PC_W_DEF-1:0] PROG2_BASE_DEF = 10'd512;
    localparam logic [PC_W_DEF-1:0] PROG3_BASE_DEF = 10'd768;

    // With num_progs = 1 the index is always at the last program, so it
    // stays pinned at 0.
    function automatic logic [1:0] next_prog(input logic [1:0] idx, input int num_progs);
        if (int'(idx) >= num_progs - 1) begin
            return 2'd0;
        end
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones instead of wrapping.
//   Clk   : clock, posedge
//   Reset : synchronous active-high reset, count -> 0
//   Clr   : synchronous clear, wins over En
//   En    : count up by one (ignored once at all-ones)
//   Count : current count
//   AtMax : Count is all-ones
module sat_counter
    import run_ctrl_pkg::*;
#(
    parameter int W = CYC_W_DEF
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Clr,
    input  logic         En,
    output logic [W-1:0] Count,
    output logic         AtMax
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign AtMax = (count_q == {W{1'b1}});
    assign Count = count_q;

    always_comb begin
        count_d = count_q;
        if (Clr) begin
            count_d = '0;
        end else if (En && !AtMax) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: program-run sequencer between the bench Start/Ack handshake and
// the processor core.
//   Clk, Reset : clock (posedge) and synchronous active-high reset
//   Start      : high arms the sequencer, falling level launches a run;
//                high during a run aborts it
//   Halt       : program finished, only looked at while running
//   CoreRun    : core enable, 0 freezes ProgCtr/RegFile/DataMem
//   PCLoad     : one-cycle strobe telling ProgCtr to load PCInit
//   PCInit     : base address of the program selected by ProgIdx
//   Ack        : run complete, held until the next Start
//   TimedOut   : last run was ended by the watchdog rather than Halt
//   ProgIdx    : program to run next / currently running
//   CycleCt    : RUN cycles of the current or last run
//   DbgState   : registered sequencer state for observation
// Handshake: a run is requested by holding Start high for one or more cycles
// and then dropping it; completion is signalled by Ack, which stays high until
// Start is raised again. All outputs are decoded from registered state.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int              PC_W       = PC_W_DEF,
    parameter int              CYC_W      = CYC_W_DEF,
    parameter int              NUM_PROGS  = 3,
    parameter logic [PC_W-1:0] PROG0_BASE = PC_W'(PROG0_BASE_DEF),
    parameter logic [PC_W-1:0] PROG1_BASE = PC_W'(PROG1_BASE_DEF),
    parameter logic [PC_W-1:0] PROG2_BASE = PC_W'(PROG2_BASE_DEF),
    parameter logic [PC_W-1:0] PROG3_BASE = PC_W'(PROG3_BASE_DEF),
    parameter logic [CYC_W-1:0] TIMEOUT   = {CYC_W{1'b1}}
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    output logic             CoreRun,
    output logic             PCLoad,
    output logic [PC_W-1:0]  PCInit,
    output logic             Ack,
    output logic             TimedOut,
    output logic [1:0]       ProgIdx,
    output logic [CYC_W-1:0] CycleCt,
    output state_e           DbgState
);

    state_e           state_q, state_d;
    logic [1:0]       prog_idx_q, prog_idx_d;
    logic             timed_out_q, timed_out_d;
    logic [CYC_W-1:0] cyc_count;
    logic             cyc_at_max;
    logic             cyc_clr;
    logic             cyc_en;
    logic             wd_fire;

    // The counter stops at TIMEOUT while running, so it never passes it;
    // AtMax only matters when TIMEOUT itself is all-ones.
    assign wd_fire = (cyc_count == TIMEOUT) || cyc_at_max;

    always_comb begin
        state_d     = state_q;
        prog_idx_d  = prog_idx_q;
        timed_out_d = timed_out_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!Start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Priority: abort by Start, then Halt, then watchdog.
                if (Start) begin
                    state_d = ST_ARM;
                end else if (Halt) begin
                    state_d    = ST_DONE;
                    prog_idx_d = next_prog(prog_idx_q, NUM_PROGS);
                end else if (wd_fire) begin
                    state_d     = ST_DONE;
                    timed_out_d = 1'b1;
                    prog_idx_d  = next_prog(prog_idx_q, NUM_PROGS);
                end
            end
            ST_DONE: begin
                if (Start) state_d = ST_ARM;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Entering ARM starts a fresh run record.
        if (state_d == ST_ARM) begin
            timed_out_d = 1'b0;
        end
    end

    // Clearing on entry to ARM means CycleCt already reads 0 throughout ARM.
    assign cyc_clr = (state_d == ST_ARM);
    // The watchdog cycle itself does not count, freezing CycleCt at TIMEOUT.
    assign cyc_en  = (state_q == ST_RUN) && !wd_fire;

    sat_counter #(
        .W (CYC_W)
    ) u_cyc_ctr (
        .Clk   (Clk),
        .Reset (Reset),
        .Clr   (cyc_clr),
        .En    (cyc_en),
        .Count (cyc_count),
        .AtMax (cyc_at_max)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            prog_idx_q  <= 2'd0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_idx_q  <= prog_idx_d;
            timed_out_q <= timed_out_d;
        end
    end

    always_comb begin
        PCInit = PROG0_BASE;
        case (prog_idx_q)
            2'd0: PCInit = PROG0_BASE;
            2'd1: PCInit = PROG1_BASE;
            2'd2: PCInit = PROG2_BASE;
            2'd3: PCInit = PROG3_BASE;
            default: PCInit = PROG0_BASE;
        endcase
    end

    assign CoreRun  = (state_q == ST_RUN);
    assign PCLoad   = (state_q == ST_LOAD);
    assign Ack      = (state_q == ST_DONE);
    assign TimedOut = timed_out_q;
    assign ProgIdx  = prog_idx_q;
    assign CycleCt  = cyc_count;
    assign DbgState = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized run sequences against a run-outcome model; each
// requested run pushes its expected outcome, a monitor compares it whenever
// the core enable drops.
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    localparam int TIMEOUT_TB = 50;
    localparam int NPROGS_TB  = 3;
    localparam int EXP_W      = 46;

    localparam int C_WD    = 0;
    localparam int C_HALT  = 1;
    localparam int C_ABORT = 2;
    localparam int C_RST   = 3;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Halt;
    logic        CoreRun;
    logic        PCLoad;
    logic [9:0]  PCInit;
    logic        Ack;
    logic        TimedOut;
    logic [1:0]  ProgIdx;
    logic [15:0] CycleCt;
    state_e      DbgState;

    int errors = 0;
    int checks = 0;

    logic [EXP_W-1:0] exp_q[$];
    int model_prog = 0;

    run_ctrl #(
        .NUM_PROGS (NPROGS_TB),
        .TIMEOUT   (16'(TIMEOUT_TB))
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Halt     (Halt),
        .CoreRun  (CoreRun),
        .PCLoad   (PCLoad),
        .PCInit   (PCInit),
        .Ack      (Ack),
        .TimedOut (TimedOut),
        .ProgIdx  (ProgIdx),
        .CycleCt  (CycleCt),
        .DbgState (DbgState)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] base_of(input int idx);
        case (idx)
            0: return 10'd0;
            1: return 10'd256;
            2: return 10'd512;
            default: return 10'd768;
        endcase
    endfunction

    // Outcome of one run from the event times (RUN cycle numbers, 1-based,
    // 0 = never). The watchdog ends a run on RUN cycle TIMEOUT+1, when the
    // count has reached TIMEOUT; on ties abort beats Halt beats watchdog.
    task automatic push_expected(input int halt_at, input int abort_at, input int rst_at,
                                 output int cause);
        int          end_k;
        logic        e_ack;
        logic        e_to;
        logic [15:0] e_cyc;
        logic [9:0]  e_pc;
        e_pc  = base_of(model_prog);
        end_k = TIMEOUT_TB + 1;
        cause = C_WD;
        if (halt_at != 0 && halt_at <= end_k) begin end_k = halt_at;  cause = C_HALT;  end
        if (abort_at != 0 && abort_at <= end_k) begin end_k = abort_at; cause = C_ABORT; end
        if (rst_at != 0 && rst_at <= end_k) begin end_k = rst_at;   cause = C_RST;   end
        e_ack = 1'b0;
        e_to  = 1'b0;
        e_cyc = 16'd0;
        case (cause)
            C_WD: begin
                e_ack = 1'b1; e_to = 1'b1; e_cyc = 16'(TIMEOUT_TB);
                model_prog = (model_prog + 1) % NPROGS_TB;
            end
            C_HALT: begin
                e_ack = 1'b1;
                e_cyc = 16'((end_k > TIMEOUT_TB) ? TIMEOUT_TB : end_k);
                model_prog = (model_prog + 1) % NPROGS_TB;
            end
            C_RST: model_prog = 0;
            default: ;
        endcase
        exp_q.push_back({e_ack, e_to, 2'(model_prog), e_cyc, e_pc, 16'(end_k)});
    endtask

    // One run: hold Start for 'hold' cycles, drop it, then drive Halt/Start/
    // Reset on the requested RUN cycles. DUT outputs are used only to pace.
    task automatic do_run(input int hold, input int halt_at, input int abort_at, input int rst_at);
        int cause;
        int n;
        int k;
        push_expected(halt_at, abort_at, rst_at, cause);
        Start = 1'b1;
        for (int i = 0; i < hold; i++) begin
            Halt = 1'($urandom_range(0, 1));
            @(negedge Clk);
        end
        Start = 1'b0;
        Halt  = 1'b0;
        n = 0;
        while (!CoreRun && n < 10) begin
            @(negedge Clk);
            n++;
        end
        if (!CoreRun) begin
            checks++;
            errors++;
            $display("FAIL run_start_timeout: got CoreRun=0 expected 1 within 10 cycles");
            void'(exp_q.pop_back());
            return;
        end
        k = 0;
        while (CoreRun && k < 300) begin
            k++;
            Halt  = (k == halt_at);
            Start = (k == abort_at);
            Reset = (k == rst_at);
            @(negedge Clk);
        end
        Halt  = 1'b0;
        Reset = 1'b0;
        if (CoreRun) begin
            checks++;
            errors++;
            $display("FAIL run_end_timeout: got CoreRun=1 expected 0 within 300 cycles");
        end
        if (cause != C_ABORT) begin
            // Idle gap; Halt wiggles to confirm it is ignored outside RUN.
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                Halt = 1'($urandom_range(0, 1));
                @(negedge Clk);
            end
            Halt = 1'b0;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic             mon_prev_run = 1'b0;
    int               mon_run_ct   = 0;
    int               mon_pl_ct    = 0;
    logic [9:0]       mon_pc       = '0;
    logic [EXP_W-1:0] e;

    always @(negedge Clk) begin
        if (CoreRun) mon_run_ct++;
        if (PCLoad) begin
            mon_pl_ct++;
            mon_pc = PCInit;
        end
        if (mon_prev_run && !CoreRun) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_run_end: got a run end expected none");
            end else begin
                e = exp_q.pop_front();
                check("ack",        Ack,        e[45]);
                check("timed_out",  TimedOut,   e[44]);
                check("prog_idx",   ProgIdx,    e[43:42]);
                check("cycle_ct",   CycleCt,    e[41:26]);
                check("pc_init",    mon_pc,     e[25:16]);
                check("run_cycles", mon_run_ct, e[15:0]);
                check("pcload_cnt", mon_pl_ct,  1);
            end
            mon_run_ct = 0;
            mon_pl_ct  = 0;
        end
        mon_prev_run = CoreRun;
    end

    // ---------------- stimulus ----------------
    initial begin
        int h;
        int a;
        Reset = 1'b1;
        Start = 1'b0;
        Halt  = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_state",    int'(DbgState), int'(ST_IDLE));
        check("rst_core_run", CoreRun,  0);
        check("rst_pcload",   PCLoad,   0);
        check("rst_ack",      Ack,      0);
        check("rst_timed_out", TimedOut, 0);
        check("rst_prog_idx", ProgIdx,  0);
        check("rst_cycle_ct", CycleCt,  0);
        check("rst_pc_init",  PCInit,   0);

        do_run(3, 20, 0, 0);
        do_run($urandom_range(1, 4), $urandom_range(1, 40), 0, 0);
        do_run($urandom_range(1, 4), $urandom_range(1, 40), 0, 0);
        do_run(2, 0, 0, 0);                 // watchdog
        do_run(2, 0, 10, 0);                // abort at RUN cycle 10
        do_run(2, 15, 0, 0);                // same program rerun
        do_run(2, 12, 12, 0);               // Start and Halt together
        do_run(2, TIMEOUT_TB + 1, 0, 0);    // Halt with watchdog expiry

        for (int r = 0; r < 20; r++) begin
            h = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 55));
            a = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 30)) : 0;
            do_run($urandom_range(1, 5), h, a, 0);
        end

        while (model_prog != 2) do_run(1, $urandom_range(1, 10), 0, 0);
        do_run(2, 0, 0, 7);                 // reset during program 2
        do_run(2, 9, 0, 0);                 // sequence restarts at program 0

        repeat (4) @(negedge Clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
